// File: rtl/secuenciador_pkg.sv
// secuenciador_pkg: branch/op codes and FSM state encoding for the PC sequencer.
package secuenciador_pkg;
  localparam logic [2:0] BC_BZ   = 3'b000;
  localparam logic [2:0] BC_BN   = 3'b001;
  localparam logic [2:0] BC_BNZ  = 3'b010;
  localparam logic [2:0] BC_BNN  = 3'b011;
  localparam logic [2:0] BC_BRA  = 3'b100;
  localparam logic [2:0] BC_CALL = 3'b101;
  localparam logic [2:0] BC_RET  = 3'b110;
  localparam logic [2:0] BC_HALT = 3'b111;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_HALT = 2'd1, ST_FAULT = 2'd2} state_t;
endpackage

// File: rtl/secuenciador_pc_pila_retorno.sv
// pila_retorno: LIFO return-address stack, combinational top-of-stack read.
//   clk, rst      clock, sync active-high reset (clears sp only)
//   push, pop     mutually exclusive, caller guarantees no push when full / pop when empty
//   din, dout     entry written on push / current top entry
//   sp            occupancy; full, empty status
module pila_retorno #(
  parameter int DEPTH = 4,
  parameter int W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         full,
  output logic                         empty
);
  localparam int SW = $clog2(DEPTH + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [SW-1:0] top;
  assign top = sp - SW'(1);
  assign dout = mem[top[AW-1:0]];
  assign full = sp == SW'(DEPTH);
  assign empty = sp == '0;
  always_ff @(posedge clk)
    if (push) mem[sp[AW-1:0]] <= din;
  always_ff @(posedge clk)
    if (rst) sp <= '0;
    else if (push) sp <= sp + SW'(1);
    else if (pop) sp <= sp - SW'(1);
endmodule

// File: rtl/secuenciador_pc.sv
// secuenciador_pc: program-counter sequencer with flags, call/return stack, HALT and sticky FAULT.
//   clk, rst        clock, sync active-high reset (beats en)
//   en              advance enable, 0 holds all state
//   pl, jb, bc, ad  decoder controls: transfer, jump-to-busA, op code, signed offset
//   busA            jump / call target
//   N, Z            function-unit flags, registered on every enabled RUN edge
//   resume          leaves HALT
//   pc              instruction address; halted, fault status; sp stack occupancy
module secuenciador_pc
  import secuenciador_pkg::*;
#(
  parameter int PC_W = 16,
  parameter int AD_W = 6,
  parameter int STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              pl,
  input  logic                              jb,
  input  logic [2:0]                        bc,
  input  logic [AD_W-1:0]                   ad,
  input  logic [PC_W-1:0]                   busA,
  input  logic                              N,
  input  logic                              Z,
  input  logic                              resume,
  output logic [PC_W-1:0]                   pc,
  output logic                              halted,
  output logic                              fault,
  output logic [$clog2(STACK_DEPTH+1)-1:0]  sp
);
  state_t state, nstate;
  logic nst, zst, take, full, empty, push, pop, cond_op;
  logic [PC_W-1:0] pc_n, inc, tgt, dout;
  assign inc = pc + PC_W'(1);
  assign tgt = pc + {{(PC_W-AD_W){ad[AD_W-1]}}, ad};
  assign cond_op = state == ST_RUN && pl && !jb;
  // Stack ops only on edges that actually commit; overflow/underflow never touch it.
  assign push = en && cond_op && bc == BC_CALL && !full;
  assign pop = en && cond_op && bc == BC_RET && !empty;
  pila_retorno #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_pila (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(inc),
    .dout(dout), .sp(sp), .full(full), .empty(empty)
  );
  always_ff @(posedge clk)
    if (rst) state <= ST_RUN;
    else if (en) state <= nstate;
  always_comb begin
    nstate = state;
    if (cond_op)
      nstate = bc == BC_HALT ? ST_HALT :
               (bc == BC_CALL && full) || (bc == BC_RET && empty) ? ST_FAULT : ST_RUN;
    else if (state == ST_HALT && resume)
      nstate = ST_RUN;
  end
  always_comb begin
    halted = state == ST_HALT;
    fault = state == ST_FAULT;
  end
  always_comb begin
    take = bc == BC_BZ ? zst : bc == BC_BN ? nst : bc == BC_BNZ ? !zst : bc == BC_BNN ? !nst : 1'b1;
    pc_n = state == ST_HALT ? (resume ? inc : pc) :
           state == ST_FAULT ? pc :
           !pl ? inc :
           jb ? busA :
           bc == BC_CALL ? (full ? pc : busA) :
           bc == BC_RET ? (empty ? pc : dout) :
           bc == BC_HALT ? pc :
           take ? tgt : inc;
  end
  always_ff @(posedge clk)
    if (rst) begin
      pc <= RESET_VEC;
      nst <= 1'b0;
      zst <= 1'b0;
    end else if (en) begin
      pc <= pc_n;
      if (state == ST_RUN) begin
        nst <= N;
        zst <= Z;
      end
    end
endmodule

// File: tb/tb_secuenciador_pc.sv
// tb_secuenciador_pc: directed scoreboard bench for secuenciador_pc.
module tb_secuenciador_pc;
  import secuenciador_pkg::*;
  logic clk = 0, rst, en, pl, jb, N, Z, resume;
  logic [2:0] bc, sp;
  logic [5:0] ad;
  logic [15:0] busA, pc;
  logic halted, fault;
  int checks = 0, errors = 0;
  typedef struct {
    string tag;
    logic [15:0] pc;
    logic h, f;
    logic [2:0] sp;
  } exp_t;
  exp_t q[$];

  secuenciador_pc dut (
    .clk(clk), .rst(rst), .en(en), .pl(pl), .jb(jb), .bc(bc), .ad(ad), .busA(busA),
    .N(N), .Z(Z), .resume(resume), .pc(pc), .halted(halted), .fault(fault), .sp(sp)
  );

  always #5 clk = ~clk;

  task automatic step(input string tag, input logic r, e, p, j, input logic [2:0] b,
                      input logic [5:0] a, input logic [15:0] ba, input logic n, z, rs,
                      input logic [15:0] epc, input logic eh, ef, input logic [2:0] esp);
    exp_t x;
    rst = r; en = e; pl = p; jb = j; bc = b; ad = a; busA = ba; N = n; Z = z; resume = rs;
    q.push_back('{tag, epc, eh, ef, esp});
    @(posedge clk);
    #1;
    x = q.pop_front();
    checks++;
    assert (pc === x.pc) else begin errors++; $error("FAIL %s pc got %h want %h", x.tag, pc, x.pc); end
    checks++;
    assert (halted === x.h) else begin errors++; $error("FAIL %s halted got %b want %b", x.tag, halted, x.h); end
    checks++;
    assert (fault === x.f) else begin errors++; $error("FAIL %s fault got %b want %b", x.tag, fault, x.f); end
    checks++;
    assert (sp === x.sp) else begin errors++; $error("FAIL %s sp got %0d want %0d", x.tag, sp, x.sp); end
  endtask

  task automatic adv(input string tag, input logic [15:0] epc);
    step(tag, 0, 1, 0, 0, 3'b0, 6'h0, 16'h0, 0, 0, 0, epc, 0, 0, 3'd0);
  endtask

  initial begin
    rst = 1; en = 0; pl = 0; jb = 0; bc = 0; ad = 0; busA = 0; N = 0; Z = 0; resume = 0;
    step("rst0", 1, 1, 0, 0, 3'b0, 6'h0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 3'd0);
    step("rst1", 1, 1, 0, 0, 3'b0, 6'h0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 3'd0);
    adv("inc1", 16'h1);
    adv("inc2", 16'h2);
    step("inc3z", 0, 1, 0, 0, 3'b0, 6'h0, 16'h0, 0, 1, 0, 16'h3, 0, 0, 3'd0);
    step("bz_taken", 0, 1, 1, 0, BC_BZ, 6'h3E, 16'h0, 0, 0, 0, 16'h1, 0, 0, 3'd0);
    step("bz_not", 0, 1, 1, 0, BC_BZ, 6'h3E, 16'h0, 0, 0, 0, 16'h2, 0, 0, 3'd0);
    step("jmp", 0, 1, 1, 1, BC_BZ, 6'h0, 16'h1234, 0, 0, 0, 16'h1234, 0, 0, 3'd0);
    step("rst2", 1, 1, 0, 0, 3'b0, 6'h0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 3'd0);
    step("bra_wrap", 0, 1, 1, 0, BC_BRA, 6'h3F, 16'h0, 0, 0, 0, 16'hFFFF, 0, 0, 3'd0);
    step("inc_wrap", 0, 1, 0, 0, 3'b0, 6'h0, 16'h0, 1, 0, 0, 16'h0000, 0, 0, 3'd0);
    step("bn_taken", 0, 1, 1, 0, BC_BN, 6'h02, 16'h0, 0, 0, 0, 16'h2, 0, 0, 3'd0);
    step("bn_not", 0, 1, 1, 0, BC_BN, 6'h02, 16'h0, 0, 0, 0, 16'h3, 0, 0, 3'd0);
    step("bnn_taken", 0, 1, 1, 0, BC_BNN, 6'h3E, 16'h0, 0, 0, 0, 16'h1, 0, 0, 3'd0);
    step("bnz_taken", 0, 1, 1, 0, BC_BNZ, 6'h04, 16'h0, 0, 0, 0, 16'h5, 0, 0, 3'd0);
    step("call", 0, 1, 1, 0, BC_CALL, 6'h0, 16'h0040, 0, 0, 0, 16'h0040, 0, 0, 3'd1);
    step("ret", 0, 1, 1, 0, BC_RET, 6'h0, 16'h0, 0, 0, 0, 16'h6, 0, 0, 3'd0);
    for (int i = 1; i <= 4; i++)
      step("nest_call", 0, 1, 1, 0, BC_CALL, 6'h0, 16'(i * 256), 0, 0, 0, 16'(i * 256), 0, 0, 3'(i));
    step("nest_ret", 0, 1, 1, 0, BC_RET, 6'h0, 16'h0, 0, 0, 0, 16'h0301, 0, 0, 3'd3);
    step("recall", 0, 1, 1, 0, BC_CALL, 6'h0, 16'h0400, 0, 0, 0, 16'h0400, 0, 0, 3'd4);
    step("overflow", 0, 1, 1, 0, BC_CALL, 6'h0, 16'h0500, 0, 0, 0, 16'h0400, 0, 1, 3'd4);
    step("fault_hold", 0, 1, 1, 0, BC_RET, 6'h0, 16'h0, 0, 0, 1, 16'h0400, 0, 1, 3'd4);
    step("rst3", 1, 1, 0, 0, 3'b0, 6'h0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 3'd0);
    step("underflow", 0, 1, 1, 0, BC_RET, 6'h0, 16'h0, 0, 0, 0, 16'h0, 0, 1, 3'd0);
    step("uf_hold0", 0, 1, 0, 0, 3'b0, 6'h0, 16'h0, 1, 1, 1, 16'h0, 0, 1, 3'd0);
    step("uf_hold1", 0, 1, 1, 1, 3'b0, 6'h0, 16'h0077, 0, 0, 0, 16'h0, 0, 1, 3'd0);
    step("rst4", 1, 1, 0, 0, 3'b0, 6'h0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 3'd0);
    for (int i = 1; i <= 9; i++) adv("run9", 16'(i));
    step("halt", 0, 1, 1, 0, BC_HALT, 6'h0, 16'h0, 0, 0, 0, 16'h9, 1, 0, 3'd0);
    for (int i = 0; i < 5; i++)
      step("halt_hold", 0, 1, 1, i[0], BC_BRA, 6'h05, 16'h0800, i[1], i[0], 0, 16'h9, 1, 0, 3'd0);
    step("halt_en0", 0, 0, 0, 0, 3'b0, 6'h0, 16'h0, 0, 0, 1, 16'h9, 1, 0, 3'd0);
    step("resume", 0, 1, 0, 0, 3'b0, 6'h0, 16'h0, 0, 0, 1, 16'hA, 0, 0, 3'd0);
    step("setz", 0, 1, 0, 0, 3'b0, 6'h0, 16'h0, 0, 1, 0, 16'hB, 0, 0, 3'd0);
    step("stall0", 0, 0, 1, 0, BC_CALL, 6'h0, 16'h0900, 1, 0, 0, 16'hB, 0, 0, 3'd0);
    step("stall1", 0, 0, 1, 0, BC_BRA, 6'h07, 16'h0, 0, 1, 0, 16'hB, 0, 0, 3'd0);
    step("stall2", 0, 0, 0, 0, 3'b0, 6'h0, 16'h0, 1, 0, 0, 16'hB, 0, 0, 3'd0);
    step("bz_after_stall", 0, 1, 1, 0, BC_BZ, 6'h04, 16'h0, 0, 0, 0, 16'hF, 0, 0, 3'd0);
    step("rst_en0", 1, 0, 1, 1, 3'b0, 6'h0, 16'h0123, 0, 0, 0, 16'h0, 0, 0, 3'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
